led_compactor: RTL

Parametrised observation compactor that reduces NUM_CH wide core-output channels to an OUT_W-bit board-visible result. It is the registered, multi-mode successor to the purely combinational XOR-reduction driving `led` in the multi-core top level. It sits between the core instances (CPU, hash, filter, MIPS) and the LED pins. Beyond a plain XOR it offers per-channel masking, single-channel select, a running MISR signature, and a windowed signature with a valid strobe, so core activity stays observable on 16 LEDs without being optimised away.

---
 rtl/led_compactor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/led_compactor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_compactor - folds core channels into an LED word (XOR/select/MISR) r1.0 |
// +----------------------------------------------------------------------------+
module led_compactor #(
  parameter int               NUM_CH = 4,
  parameter int               CH_W   = 32,
  parameter int               OUT_W  = 16,
  parameter logic [OUT_W-1:0] POLY   = 16'h1021,
  parameter int               WINDOW = 1024,
  localparam int              SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     freeze,
  output logic [OUT_W-1:0]         led,
  output logic                     sig_valid
);

  localparam int NUM_SL = (CH_W + OUT_W - 1) / OUT_W;
  localparam int CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [1:0] C_MODE_XOR  = 2'd0;
  localparam logic [1:0] C_MODE_MISR = 2'd1;
  localparam logic [1:0] C_MODE_SEL  = 2'd2;
  localparam logic [1:0] C_MODE_WIN  = 2'd3;

  logic [NUM_SL*OUT_W-1:0] padded;
  logic [OUT_W-1:0]        fold_d [NUM_CH];
  logic [OUT_W-1:0]        fold_q [NUM_CH];
  logic [OUT_W-1:0]        comb_d, comb_q;
  logic [OUT_W-1:0]        selq_d, selq_q;
  logic [OUT_W-1:0]        misr_d, misr_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic [1:0]              mode_q;
  logic [OUT_W-1:0]        led_d, led_q;
  logic                    sig_valid_d, sig_valid_q;

  logic                    mode_chg;
  logic [OUT_W-1:0]        misr_base, misr_nx;
  logic [CNT_W-1:0]        cnt_base;
  logic                    win_last;

  always_comb begin
    padded = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      padded             = '0;
      padded[CH_W-1:0]   = ch_data[i*CH_W +: CH_W];
      fold_d[i]          = '0;
      for (int s = 0; s < NUM_SL; s++) begin
        fold_d[i] = fold_d[i] ^ padded[s*OUT_W +: OUT_W];
      end
    end
  end

  always_comb begin
    comb_d = '0;
    selq_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_en[i]) comb_d = comb_d ^ fold_q[i];
      if (int'(sel) == i) selq_d = fold_q[i];
    end
  end

  // A mode change restarts the signature: the update on that edge starts from zero.
  always_comb begin
    mode_chg  = (mode != mode_q);
    misr_base = mode_chg ? '0 : misr_q;
    cnt_base  = mode_chg ? '0 : cnt_q;
    win_last  = (cnt_base == CNT_W'(WINDOW - 1));
    misr_nx   = {misr_base[OUT_W-2:0], 1'b0} ^ (misr_base[OUT_W-1] ? POLY : '0) ^ comb_q;

    misr_d      = '0;
    cnt_d       = '0;
    led_d       = led_q;
    sig_valid_d = 1'b0;
    case (mode)
      C_MODE_XOR:  led_d = comb_q;
      C_MODE_MISR: begin
        misr_d = misr_nx;
        led_d  = misr_nx;
      end
      C_MODE_SEL:  led_d = selq_q;
      C_MODE_WIN: begin
        if (win_last) begin
          led_d       = misr_nx;
          sig_valid_d = 1'b1;
        end else begin
          misr_d = misr_nx;
          cnt_d  = cnt_base + CNT_W'(1);
        end
      end
      default: led_d = led_q;
    endcase

    // Freeze only gates the visible outputs; the signature keeps running.
    if (freeze) begin
      led_d       = led_q;
      sig_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) fold_q[i] <= '0;
      comb_q      <= '0;
      selq_q      <= '0;
      misr_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      led_q       <= '0;
      sig_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) fold_q[i] <= fold_d[i];
      comb_q      <= comb_d;
      selq_q      <= selq_d;
      misr_q      <= misr_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode;
      led_q       <= led_d;
      sig_valid_q <= sig_valid_d;
    end
  end

  assign led       = led_q;
  assign sig_valid = sig_valid_q;

endmodule
`default_nettype wire
